model_seq_ctrl: RTL and testbench
=================================

Name: model_seq_ctrl

Overview:
Parametrised top-level sequencer for the LM accelerator; successor to the single-stage layer controller. It walks a runtime-configurable number of transformer layers. Each layer is a chain of NUM_STAGE sub-stages (e.g. LN, QKV, attention, linear1, linear2), and each sub-stage gets its own start/done handshake. After the last layer it launches the output stage. It adds abort, a per-stage watchdog, and status outputs for the host/debug path.

Parameters:
MAX_LAYER, 12, upper bound on layers; sets the width of the layer count and index.
NUM_STAGE, 5, sub-stages per layer, issued in order 0..NUM_STAGE-1 (must be >=1).
TIMEOUT_CYC, 0, cycles allowed between a start pulse and its done; 0 disables the watchdog.
LW = $clog2(MAX_LAYER+1), SW = max(1,$clog2(NUM_STAGE)), TW = max(1,$clog2(TIMEOUT_CYC+1)) (derived localparams).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  level/pulse; sampled only in IDLE
num_layer_cfg  in  LW  layer count, latched on accepted start
stage_done  in  NUM_STAGE  per-stage done pulses from the datapath
out_done  in  1  output stage complete
abort  in  1  synchronous cancel request
stage_start  out  NUM_STAGE  one-hot, one-cycle start pulse to the current stage
out_start  out  1  one-cycle pulse launching the output stage
done  out  1  one-cycle completion pulse
aborted  out  1  one-cycle pulse confirming an abort
busy  out  1  high in every state except IDLE
layer_idx  out  LW  current layer (0-based)
stage_idx  out  SW  current stage
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE. stage_start=0, out_start=0, done=0, aborted=0, busy=0, layer_idx=0, stage_idx=0, timeout_err=0, watchdog count=0, latched layer count=0.
- All outputs are registered. stage_start, out_start, done and aborted default to 0 every cycle, so each is a single-cycle pulse.
- States: IDLE, RUN (waiting on stage_done[stage_idx]), OUT (waiting on out_done).
- IDLE with start=1 at edge k:
  - Latch N = min(num_layer_cfg, MAX_LAYER). Clear layer_idx, stage_idx and timeout_err.
  - If N>0: go to RUN; stage_start[0] is high during cycle k+1.
  - If N==0: go to OUT; out_start is high during cycle k+1.
- RUN: only stage_done[stage_idx] is honoured. Other bits are ignored and do not change state or set errors. When stage_done[stage_idx]=1 at an edge, exactly one of the following takes effect on the next cycle:
  - stage_idx < NUM_STAGE-1: stage_idx+1, and the matching stage_start bit pulses.
  - Last stage, layer_idx < N-1: layer_idx+1, stage_idx=0, stage_start[0] pulses.
  - Last stage, last layer: go to OUT, out_start pulses. layer_idx and stage_idx hold their final values.
- Zero-bubble latency: a done at edge j produces the next start in cycle j+1.
- OUT: out_done=1 at an edge returns the block to IDLE; done pulses in the next cycle and busy drops in that same cycle.
- start while busy is ignored, with no relatch.
- Abort: highest priority in RUN and OUT. The block goes to IDLE, aborted pulses the next cycle, and no start, out_start or done pulse is issued that cycle even if a done arrived simultaneously. Abort in IDLE has no effect (no aborted pulse). layer_idx and stage_idx hold their values for debug until the next accepted start.
- Watchdog (TIMEOUT_CYC>0):
  - The counter clears on every start pulse issued (stage_start or out_start) and increments each cycle in RUN or OUT.
  - If it reaches TIMEOUT_CYC before the awaited done: timeout_err is set, the block goes to IDLE, and done does not pulse.
  - A done arriving on the same edge as the timeout wins, and no error is set.
  - timeout_err stays high until reset or the next accepted start.
- Counter widths never overflow. layer_idx ≤ MAX_LAYER-1 and stage_idx ≤ NUM_STAGE-1 are guaranteed by the clamp.

Test Plan:
- NUM_STAGE=3, cfg=2, each stage_done returned 1 cycle after its start -> stage_start sequence 001,010,100,001,010,100; then out_start; out_done -> done pulses once; busy is low in the done cycle.
- cfg=0, start -> out_start the next cycle, no stage_start ever; out_done -> done.
- cfg=15 with MAX_LAYER=12 -> exactly 12 layers run; layer_idx peaks at 11.
- In RUN at stage 1 of layer 3, drive stage_done=3'b101 (wrong bits) -> no change; then assert abort simultaneously with stage_done[1] -> aborted pulses, no stage_start, busy=0, layer_idx=3, stage_idx=1 held.
- TIMEOUT_CYC=8, withhold stage_done -> timeout_err set exactly 8 cycles after the stage_start cycle, state IDLE, no done; next start clears timeout_err.
- Assert reset mid-RUN -> all outputs go to 0 immediately (asynchronously); a start after reset release runs a full sequence normally.

Source files
------------

// File: rtl/model_seq_ctrl.sv
// -----------------------------------------------------------------------------
// model_seq_ctrl
//
// Top-level sequencer for the LM accelerator. It walks a runtime-configurable
// number of transformer layers. Each layer is a chain of NUM_STAGE sub-stages,
// issued in order 0..NUM_STAGE-1. After the last layer the sequencer launches
// the output stage. It also provides abort, a per-stage watchdog, and status
// outputs for the host/debug path.
//
// Handshake semantics (all stage/output interfaces):
//   The sequencer issues a one-cycle start pulse. It then waits any number of
//   cycles for the matching one-cycle done pulse. A done that is sampled at
//   edge j produces the next start pulse in cycle j+1, so there is no bubble.
//   A done bit that does not belong to the awaited stage is ignored.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all state and outputs
//   start          run request; sampled only while idle
//   num_layer_cfg  layer count; clamped to MAX_LAYER and latched on start
//   stage_done     per-stage done pulses from the datapath
//   out_done       output stage complete
//   abort          synchronous cancel request (ignored while idle)
//   stage_start    one-hot, one-cycle start pulse to the current stage
//   out_start      one-cycle pulse launching the output stage
//   done           one-cycle completion pulse
//   aborted        one-cycle pulse confirming an abort
//   busy           high in every state except idle
//   layer_idx      current layer (0-based)
//   stage_idx      current stage
//   timeout_err    sticky watchdog flag; cleared by reset or an accepted start
// -----------------------------------------------------------------------------
module model_seq_ctrl #(
   parameter int  MAX_LAYER   = 12,
   parameter int  NUM_STAGE   = 5,
   parameter int  TIMEOUT_CYC = 0,
   localparam int LW = $clog2(MAX_LAYER + 1),
   localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1,
   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LW-1:0]        num_layer_cfg,
   input  logic [NUM_STAGE-1:0] stage_done,
   input  logic                 out_done,
   input  logic                 abort,
   output logic [NUM_STAGE-1:0] stage_start,
   output logic                 out_start,
   output logic                 done,
   output logic                 aborted,
   output logic                 busy,
   output logic [LW-1:0]        layer_idx,
   output logic [SW-1:0]        stage_idx,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [LW-1:0]        MAX_L    = LW'(MAX_LAYER);
   localparam logic [SW-1:0]        LAST_S   = SW'(NUM_STAGE - 1);
   localparam logic [TW-1:0]        WD_LAST  = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
   localparam logic [NUM_STAGE-1:0] SS_FIRST = NUM_STAGE'(1);
   localparam bit                   WD_EN    = (TIMEOUT_CYC > 0);

   state_t        state;
   logic [LW-1:0] n_lat;        // latched, clamped layer count
   logic [LW-1:0] cfg_clamped;
   logic [TW-1:0] wd_cnt;       // cycles spent waiting since the last start pulse
   logic          wd_expire;

   // The counter is cleared on the edge that issues a start pulse. Expiry
   // fires on the edge where the count would reach TIMEOUT_CYC. That puts
   // timeout_err high exactly TIMEOUT_CYC cycles after the start-pulse cycle.
   always_comb begin
      cfg_clamped = (num_layer_cfg > MAX_L) ? MAX_L : num_layer_cfg;
      wd_expire   = WD_EN && (wd_cnt == WD_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         n_lat       <= '0;
         wd_cnt      <= '0;
         stage_start <= '0;
         out_start   <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         busy        <= 1'b0;
         layer_idx   <= '0;
         stage_idx   <= '0;
         timeout_err <= 1'b0;
      end else begin
         stage_start <= '0;
         out_start   <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  n_lat       <= cfg_clamped;
                  layer_idx   <= '0;
                  stage_idx   <= '0;
                  timeout_err <= 1'b0;
                  wd_cnt      <= '0;
                  busy        <= 1'b1;
                  if (cfg_clamped != '0) begin
                     state       <= RUN;
                     stage_start <= SS_FIRST;
                  end else begin
                     state     <= OUT;
                     out_start <= 1'b1;
                  end
               end
            end

            RUN: begin
               // Abort outranks a simultaneous done: no further pulse is issued.
               if (abort) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (stage_done[stage_idx]) begin
                  wd_cnt <= '0;
                  if (stage_idx != LAST_S) begin
                     stage_idx   <= stage_idx + SW'(1);
                     stage_start <= SS_FIRST << (stage_idx + SW'(1));
                  end else if (layer_idx != n_lat - LW'(1)) begin
                     layer_idx   <= layer_idx + LW'(1);
                     stage_idx   <= '0;
                     stage_start <= SS_FIRST;
                  end else begin
                     // Indices keep their final values for status readback.
                     state     <= OUT;
                     out_start <= 1'b1;
                  end
               end else if (wd_expire) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else if (WD_EN) begin
                  wd_cnt <= wd_cnt + TW'(1);
               end
            end

            OUT: begin
               if (abort) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (out_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (wd_expire) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
               end else if (WD_EN) begin
                  wd_cnt <= wd_cnt + TW'(1);
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_model_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_model_seq_ctrl
//
// Self-checking bench for model_seq_ctrl, built with NUM_STAGE=3,
// MAX_LAYER=12 and TIMEOUT_CYC=8. Driver tasks push the expected next output
// event when they drive the stimulus that causes it. A monitor packs every
// observed pulse (stage_start/out_start/done/aborted plus the indices) into a
// word. It compares that word against the front of exp_q.
// -----------------------------------------------------------------------------
module tb_model_seq_ctrl;

   localparam int MAX_LAYER   = 12;
   localparam int NUM_STAGE   = 3;
   localparam int TIMEOUT_CYC = 8;
   localparam int LW = $clog2(MAX_LAYER + 1);
   localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
   localparam int EW = 3 + NUM_STAGE + LW + SW;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [LW-1:0]        num_layer_cfg = '0;
   logic [NUM_STAGE-1:0] stage_done = '0;
   logic                 out_done = 1'b0;
   logic                 abort = 1'b0;
   logic [NUM_STAGE-1:0] stage_start;
   logic                 out_start;
   logic                 done;
   logic                 aborted;
   logic                 busy;
   logic [LW-1:0]        layer_idx;
   logic [SW-1:0]        stage_idx;
   logic                 timeout_err;

   always #5 clk = ~clk;

   model_seq_ctrl #(
      .MAX_LAYER  (MAX_LAYER),
      .NUM_STAGE  (NUM_STAGE),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_layer_cfg(num_layer_cfg),
      .stage_done   (stage_done),
      .out_done     (out_done),
      .abort        (abort),
      .stage_start  (stage_start),
      .out_start    (out_start),
      .done         (done),
      .aborted      (aborted),
      .busy         (busy),
      .layer_idx    (layer_idx),
      .stage_idx    (stage_idx),
      .timeout_err  (timeout_err)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int peak_layer = 0;
   int ss_count = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] ev(input logic d, input logic a, input logic o,
                                        input logic [NUM_STAGE-1:0] ss, input int l, input int s);
      return {d, a, o, ss, LW'(l), SW'(s)};
   endfunction

   // Monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      logic [EW-1:0] obs;
      if (!reset) begin
         if (busy && int'(layer_idx) > peak_layer) peak_layer = int'(layer_idx);
         if (stage_start != '0) ss_count++;
         if (stage_start != '0 || out_start || done || aborted) begin
            obs = ev(done, aborted, out_start, stage_start, int'(layer_idx), int'(stage_idx));
            if (exp_q.size() == 0) chk("unexpected_event", 32'(obs), 32'd0);
            else chk("event", 32'(obs), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_stage(input int s);
      int n = 0;
      while (!stage_start[s] && n < 40) begin
         step();
         n++;
      end
      if (!stage_start[s]) chk("wait_stage", 32'(stage_start), 32'(1 << s));
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_start && n < 40) begin
         step();
         n++;
      end
      if (!out_start) chk("wait_out", 32'(out_start), 32'd1);
   endtask

   // Accept start with cfg and push the first expected pulse.
   task automatic kick(input int cfg);
      int n = (cfg > MAX_LAYER) ? MAX_LAYER : cfg;
      start = 1'b1;
      num_layer_cfg = LW'(cfg);
      if (n == 0) exp_q.push_back(ev(1'b0, 1'b0, 1'b1, '0, 0, 0));
      else        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, NUM_STAGE'(1), 0, 0));
      step();
      start = 1'b0;
   endtask

   // Complete stage s of layer l in an n-layer run after d idle cycles.
   task automatic adv_stage(input int l, input int s, input int n, input int d);
      wait_stage(s);
      chk("layer_idx", 32'(layer_idx), 32'(l));
      repeat (d) step();
      stage_done = NUM_STAGE'(1 << s);
      if (s < NUM_STAGE - 1)  exp_q.push_back(ev(1'b0, 1'b0, 1'b0, NUM_STAGE'(1 << (s + 1)), l, s + 1));
      else if (l < n - 1)     exp_q.push_back(ev(1'b0, 1'b0, 1'b0, NUM_STAGE'(1), l + 1, 0));
      else                    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, '0, l, s));
      step();
      stage_done = '0;
   endtask

   task automatic finish_out(input int fl, input int fs);
      wait_out();
      out_done = 1'b1;
      start = 1'b0;
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, '0, fl, fs));
      step();
      out_done = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      step();
      chk("done_once", 32'(done), 32'd0);
   endtask

   // Full run; hold_start keeps start high (cfg=0) to show it is ignored while busy.
   task automatic run_seq(input int cfg, input bit hold_start);
      int n = (cfg > MAX_LAYER) ? MAX_LAYER : cfg;
      kick(cfg);
      if (hold_start) begin
         start = 1'b1;
         num_layer_cfg = '0;
      end
      chk("busy_run", 32'(busy), 32'd1);
      for (int l = 0; l < n; l++)
         for (int s = 0; s < NUM_STAGE; s++)
            adv_stage(l, s, n, int'($urandom_range(0, 3)));
      finish_out((n == 0) ? 0 : n - 1, (n == 0) ? 0 : NUM_STAGE - 1);
   endtask

   // ---------------- global bound ----------------
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
      $fatal(1, "bench timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      // Reset state
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stage_start", 32'(stage_start), 32'd0);
      chk("rst_idx", 32'({layer_idx, stage_idx}), 32'd0);
      chk("rst_flags", 32'({out_start, done, aborted, timeout_err}), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();

      // Two layers; start held high during the run must not relatch.
      run_seq(2, 1'b1);

      // Zero layers: straight to the output stage.
      ss_count = 0;
      run_seq(0, 1'b0);
      chk("no_stage_for_cfg0", 32'(ss_count), 32'd0);

      // Clamp: cfg=15 runs exactly MAX_LAYER layers.
      peak_layer = 0;
      ss_count = 0;
      run_seq(15, 1'b0);
      chk("peak_layer", 32'(peak_layer), 32'(MAX_LAYER - 1));
      chk("stage_pulses", 32'(ss_count), 32'(MAX_LAYER * NUM_STAGE));

      // Wrong done bits are ignored; abort beats a simultaneous done.
      kick(5);
      for (int l = 0; l < 3; l++)
         for (int s = 0; s < NUM_STAGE; s++)
            adv_stage(l, s, 5, 1);
      adv_stage(3, 0, 5, 0);
      wait_stage(1);
      stage_done = 3'b101;
      step();
      step();
      stage_done = '0;
      chk("wrong_bits_busy", 32'(busy), 32'd1);
      chk("wrong_bits_idx", 32'({layer_idx, stage_idx}), 32'({LW'(3), SW'(1)}));
      abort = 1'b1;
      stage_done = 3'b010;
      exp_q.push_back(ev(1'b0, 1'b1, 1'b0, '0, 3, 1));
      step();
      abort = 1'b0;
      stage_done = '0;
      chk("abort_pulse", 32'(aborted), 32'd1);
      chk("abort_no_start", 32'(stage_start), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_idx_hold", 32'({layer_idx, stage_idx}), 32'({LW'(3), SW'(1)}));
      step();
      abort = 1'b1;
      step();
      step();
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'd0);
      chk("idle_abort_pulse", 32'(aborted), 32'd0);

      // Watchdog: withhold stage_done.
      kick(1);
      wait_stage(0);
      repeat (TIMEOUT_CYC - 1) step();
      chk("wd_before", 32'(timeout_err), 32'd0);
      chk("wd_before_busy", 32'(busy), 32'd1);
      step();
      chk("wd_fire", 32'(timeout_err), 32'd1);
      chk("wd_idle", 32'(busy), 32'd0);
      step();
      chk("wd_sticky", 32'(timeout_err), 32'd1);
      chk("wd_no_done", 32'(done), 32'd0);

      // Next start clears the flag; a done on the expiry edge wins.
      kick(1);
      chk("wd_cleared", 32'(timeout_err), 32'd0);
      repeat (TIMEOUT_CYC - 1) step();
      stage_done = NUM_STAGE'(1);
      exp_q.push_back(ev(1'b0, 1'b0, 1'b0, NUM_STAGE'(2), 0, 1));
      step();
      stage_done = '0;
      chk("wd_done_wins_err", 32'(timeout_err), 32'd0);
      chk("wd_done_wins_busy", 32'(busy), 32'd1);
      adv_stage(0, 1, 1, 0);
      adv_stage(0, 2, 1, 2);
      finish_out(0, NUM_STAGE - 1);

      // Asynchronous reset mid-run.
      kick(3);
      adv_stage(0, 0, 3, 1);
      wait_stage(1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_outs", 32'({stage_start, out_start, done, aborted, timeout_err}), 32'd0);
      chk("async_rst_idx", 32'({layer_idx, stage_idx}), 32'd0);
      exp_q.delete();
      step();
      reset = 1'b0;
      step();
      run_seq(2, 1'b0);

      step();
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
